adc_avg_fifo: RTL and testbench
===============================

# adc_avg_fifo

Downstream consumer of the PWM-ramp ADC result stream. Takes single-cycle `sample_valid_i`/`sample_i` pulses, averages each group of 2^LOG2_AVG consecutive samples, and buffers the averages in a small first-word-fall-through FIFO. Readout uses a valid/ready handshake toward the register interface or DMA. Overflow is reported with a sticky flag.

## Interface

- `NBITS`, default 8: sample and result width.
- `LOG2_AVG`, default 2: log2 of samples per average. 0 means pass-through with no averaging.
- `DEPTH`, default 4: FIFO entries. Must be a power of two and ≥ 2.

- `clk_i`  in  1: single clock.
- `rst_i`  in  1: reset, asynchronous and active-high. Clears all state.
- `enable_i`  in  1: accept samples when high. When low, samples are ignored and the accumulator holds; FIFO reads still operate.
- `clear_i`  in  1: synchronous flush of the accumulator, FIFO and overflow flag.
- `sample_i`  in  NBITS: ADC code; sampled only when `sample_valid_i` is high.
- `sample_valid_i`  in  1: one-cycle sample strobe. There is no backpressure on this input.
- `data_o`  out  NBITS: FIFO head entry, stable while `valid_o && !ready_i`.
- `valid_o`  out  1: FIFO non-empty.
- `ready_i`  in  1: consumer ready. A pop occurs when `valid_o && ready_i`.
- `level_o`  out  $clog2(DEPTH)+1: number of FIFO entries occupied.
- `overflow_o`  out  1: sticky; set when a result is dropped because the FIFO is full.

## Operation

- **Accumulator:**
  - Accumulator `acc` is NBITS+LOG2_AVG bits wide, so it cannot overflow.
  - Sample counter `cnt` is LOG2_AVG bits wide.
  - Accepted sample means `sample_valid_i && enable_i && !clear_i`.
- **Non-completing sample** (`cnt != 2^LOG2_AVG-1`): `acc <= acc + sample_i`, `cnt <= cnt + 1`.
- **Completing sample** (`cnt == 2^LOG2_AVG-1`):
  - result = `(acc + sample_i) >> LOG2_AVG`. Truncating division; the result fits NBITS.
  - Push the result into the FIFO in the same cycle.
  - `acc <= 0`, `cnt <= 0`.
- **LOG2_AVG = 0:** every accepted sample is a completing sample, and result = `sample_i`.
- **FIFO:**
  - Circular buffer with read/write pointers one bit wider than the index, so full and empty are distinguishable.
  - `data_o` is driven from `mem[rd_ptr]`.
- **Push/pop rules:**
  - Push with FIFO not full: the entry is written and `level_o` increments, unless a simultaneous pop occurs.
  - Push with FIFO full and a simultaneous pop: the push is accepted and `level_o` stays at DEPTH.
  - Push with FIFO full and no pop: the result is dropped and `overflow_o <= 1`. FIFO contents are unchanged.
  - Push with FIFO empty: no bypass. `valid_o` rises the following cycle.
  - Simultaneous push and pop with the FIFO non-full: `level_o` is unchanged.
- **Handshake:** once `valid_o` is high, `data_o` holds until a pop. Results are delivered strictly in completion order.
- **clear_i:**
  - Has priority over any push and pop in the same cycle; both are discarded.
  - `acc`, `cnt`, both pointers and `overflow_o` are zeroed.
  - FIFO memory contents are not required to clear.
- **enable_i deasserted:** a partial average is held and resumes when `enable_i` returns high.

## Timing

- **Reset values:**
  - `valid_o` = 0, `level_o` = 0, `overflow_o` = 0.
  - `data_o` = 0; memory is reset to 0.
  - `acc` = 0, `cnt` = 0.
- **Latency:** the completing `sample_valid_i` is high in cycle N. If the FIFO was empty, `valid_o` = 1 and `data_o` = result in cycle N+1.
- **Pop:** with `valid_o && ready_i` in cycle N, the next entry (or `valid_o` = 0) appears in cycle N+1. Back-to-back pops sustain one pop per cycle.
- **Throughput:** one sample accepted per cycle. Consecutive strobes are legal.
- **Overflow flag:** `overflow_o` rises the cycle after the dropping push. It clears only on `clear_i` or `rst_i`.
- **Reset mid-operation:** asserting `rst_i` mid-accumulation or mid-handshake discards everything. The first accepted sample after reset starts a new group.

## Test plan

- **Basic average:** NBITS=8, LOG2_AVG=2. Samples 10, 20, 30, 41 on consecutive cycles with `ready_i` = 0 → one cycle later `valid_o` = 1, `data_o` = 25 (101>>2), `level_o` = 1.
- **Full scale and gaps:** four samples of 255 separated by `enable_i`-low gaps, plus a strobe during a gap → the gap strobe is ignored; result is 255 with no corruption.
- **Overflow:** DEPTH=4, `ready_i` = 0, five averages with values 1, 2, 3, 4, 5 → `level_o` = 4, `overflow_o` = 1. Then raise `ready_i` → pops return 1, 2, 3, 4 on consecutive cycles, then `valid_o` = 0.
- **Full with simultaneous push and pop:** FIFO full, completing sample in the same cycle as `ready_i` = 1 → `level_o` stays 4, `overflow_o` = 0, the new result appears last.
- **Clear priority:** `clear_i` in the same cycle as a completing sample and a pop, with `level_o` = 2 and `overflow_o` = 1 → the next cycle shows `level_o` = 0, `valid_o` = 0, `overflow_o` = 0. The next four samples of 8 give 8.
- **Reset mid-group:** two samples of 100, then a `rst_i` pulse, then four samples of 8 → `data_o` = 8, not a mix with the pre-reset samples.

Source files
------------

// File: rtl/adc_avg_fifo.sv
// adc_avg_fifo: averages groups of 2^LOG2_AVG ADC samples and queues the
// results in a first-word-fall-through FIFO read out by valid/ready.
// A result that finds the FIFO full with no pop is dropped and recorded
// in a sticky overflow flag.
module adc_avg_fifo #(
    parameter int NBITS    = 8,
    parameter int LOG2_AVG = 2,
    parameter int DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [NBITS-1:0]         sample_i,
    input  logic                     sample_valid_i,
    output logic [NBITS-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = NBITS + LOG2_AVG;
    // A zero-width counter is not legal, so pass-through mode keeps a
    // one-bit counter that never leaves zero.
    localparam int CNTW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((1 << LOG2_AVG) - 1);

    logic [ACCW-1:0]  acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [NBITS-1:0] mem_q [DEPTH];

    logic [ACCW-1:0]  sum;
    logic [NBITS-1:0] result;
    logic             accept;
    logic             complete;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             empty;
    logic             wr_en;

    assign accept   = sample_valid_i && enable_i && !clear_i;
    // With LOG2_AVG = 0 the counter is pinned at zero, which equals
    // CNT_LAST, so every accepted sample completes a group.
    assign complete = (cnt_q == CNT_LAST);
    assign push_req = accept && complete;
    assign sum      = acc_q + ACCW'(sample_i);
    assign result   = NBITS'(sum >> LOG2_AVG);

    // Pointers carry one extra wrap bit so full and empty differ.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = !empty && ready_i;

    assign valid_o    = !empty;
    assign data_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign overflow_o = overflow_q;

    // Next-state logic: clear wins over everything, otherwise accumulate,
    // pop, and push (a full FIFO still accepts a push when it pops too).
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (clear_i) begin
            acc_d      = '0;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_req) begin
                if (!full || pop) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    // State registers for the accumulator, counter, pointers and flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; reset to zero so data_o reads 0 out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= result;
        end
    end

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed testbench for adc_avg_fifo (NBITS=8, LOG2_AVG=2, DEPTH=4).
module tb_adc_avg_fifo;

    typedef struct {
        logic       en;
        logic       clr;
        logic       sv;
        logic       rdy;
        logic [7:0] sample;
        logic       expValid;
        logic [7:0] expData;
        logic [2:0] expLevel;
        logic       expOvf;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [7:0] sample;
    logic       sampleValid;
    logic [7:0] dataOut;
    logic       validOut;
    logic       ready;
    logic [2:0] levelOut;
    logic       overflowOut;

    int   checks;
    int   errors;
    vec_t vecs[$];

    adc_avg_fifo #(.NBITS(8), .LOG2_AVG(2), .DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .clear_i        (clear),
        .sample_i       (sample),
        .sample_valid_i (sampleValid),
        .data_o         (dataOut),
        .valid_o        (validOut),
        .ready_i        (ready),
        .level_o        (levelOut),
        .overflow_o     (overflowOut)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Append one cycle of stimulus and its expected post-edge outputs.
    task automatic addRow(input logic en, input logic clr, input logic sv,
                          input logic rdy, input logic [7:0] smp,
                          input logic eValid, input logic [7:0] eData,
                          input logic [2:0] eLevel, input logic eOvf);
        vec_t v;
        v.en = en; v.clr = clr; v.sv = sv; v.rdy = rdy; v.sample = smp;
        v.expValid = eValid; v.expData = eData;
        v.expLevel = eLevel; v.expOvf = eOvf;
        vecs.push_back(v);
    endtask

    // Compare outputs; data is only meaningful while valid is expected.
    task automatic checkOutput(input string name, input logic eValid,
                               input logic [7:0] eData, input logic [2:0] eLevel,
                               input logic eOvf);
        checks++;
        if (validOut !== eValid) begin
            errors++;
            $display("[TB] FAIL %s.valid got %0b expected %0b", name, validOut, eValid);
        end
        checks++;
        if (levelOut !== eLevel) begin
            errors++;
            $display("[TB] FAIL %s.level got %0d expected %0d", name, levelOut, eLevel);
        end
        checks++;
        if (overflowOut !== eOvf) begin
            errors++;
            $display("[TB] FAIL %s.overflow got %0b expected %0b", name, overflowOut, eOvf);
        end
        if (eValid) begin
            checks++;
            if (dataOut !== eData) begin
                errors++;
                $display("[TB] FAIL %s.data got %0d expected %0d", name, dataOut, eData);
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then check.
    task automatic applyStimulus(input string name, input vec_t v);
        enable      = v.en;
        clear       = v.clr;
        sampleValid = v.sv;
        ready       = v.rdy;
        sample      = v.sample;
        @(posedge clk);
        #1;
        checkOutput(name, v.expValid, v.expData, v.expLevel, v.expOvf);
    endtask

    task automatic idleInputs();
        enable = 1'b1; clear = 1'b0; sampleValid = 1'b0; ready = 1'b0; sample = 8'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idleInputs();

        // ---- Basic average: 10+20+30+41 = 101, >>2 = 25
        addRow(1, 0, 1, 0, 8'd10, 0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd20, 0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd30, 0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd41, 1, 8'd25, 1, 0);
        addRow(1, 0, 0, 1, 8'd0,  0, 0, 0, 0);

        // ---- Full scale with enable gaps; gap strobes must be ignored
        addRow(1, 0, 1, 0, 8'd255, 0, 0, 0, 0);
        addRow(0, 0, 1, 0, 8'd0,   0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd255, 0, 0, 0, 0);
        addRow(0, 0, 0, 0, 8'd0,   0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd255, 0, 0, 0, 0);
        addRow(0, 0, 1, 0, 8'd7,   0, 0, 0, 0);
        addRow(1, 0, 1, 0, 8'd255, 1, 8'd255, 1, 0);
        addRow(1, 0, 0, 1, 8'd0,   0, 0, 0, 0);

        // ---- Overflow: averages 1..5 with ready low; the 5th is dropped
        for (int k = 1; k <= 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                addRow(1, 0, 1, 0, 8'(k), (k > 1) || (j == 3), 8'd1,
                       (j == 3) ? 3'((k > 4) ? 4 : k) : 3'(k - 1),
                       (k == 5) && (j == 3));
            end
        end
        addRow(1, 0, 0, 1, 0, 1, 8'd2, 3, 1);
        addRow(1, 0, 0, 1, 0, 1, 8'd3, 2, 1);
        addRow(1, 0, 0, 1, 0, 1, 8'd4, 1, 1);
        addRow(1, 0, 0, 1, 0, 0, 8'd0, 0, 1);
        addRow(1, 1, 0, 0, 0, 0, 8'd0, 0, 0);

        // ---- Full FIFO with a completing sample and a pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                addRow(1, 0, 1, 0, 8'((i + 1) * 10), (i > 0) || (j == 3), 8'd10,
                       (j == 3) ? 3'(i + 1) : 3'(i), 0);
            end
        end
        addRow(1, 0, 1, 0, 8'd50, 1, 8'd10, 4, 0);
        addRow(1, 0, 1, 0, 8'd50, 1, 8'd10, 4, 0);
        addRow(1, 0, 1, 0, 8'd50, 1, 8'd10, 4, 0);
        addRow(1, 0, 1, 1, 8'd50, 1, 8'd20, 4, 0);
        addRow(1, 0, 0, 1, 0, 1, 8'd30, 3, 0);
        addRow(1, 0, 0, 1, 0, 1, 8'd40, 2, 0);
        addRow(1, 0, 0, 1, 0, 1, 8'd50, 1, 0);
        addRow(1, 0, 0, 1, 0, 0, 8'd0,  0, 0);

        // ---- Clear priority: reach level 2 with overflow set, then clear
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                addRow(1, 0, 1, 0, 8'(60 + k), (k > 0) || (j == 3), 8'd60,
                       (j == 3) ? 3'((k + 1 > 4) ? 4 : k + 1) : 3'(k),
                       (k == 4) && (j == 3));
            end
        end
        addRow(1, 0, 0, 1, 0, 1, 8'd61, 3, 1);
        addRow(1, 0, 0, 1, 0, 1, 8'd62, 2, 1);
        addRow(1, 0, 1, 0, 8'd9, 1, 8'd62, 2, 1);
        addRow(1, 0, 1, 0, 8'd9, 1, 8'd62, 2, 1);
        addRow(1, 0, 1, 0, 8'd9, 1, 8'd62, 2, 1);
        addRow(1, 1, 1, 1, 8'd9, 0, 8'd0, 0, 0);
        addRow(1, 0, 1, 0, 8'd8, 0, 8'd0, 0, 0);
        addRow(1, 0, 1, 0, 8'd8, 0, 8'd0, 0, 0);
        addRow(1, 0, 1, 0, 8'd8, 0, 8'd0, 0, 0);
        addRow(1, 0, 1, 0, 8'd8, 1, 8'd8, 1, 0);
        addRow(1, 0, 0, 1, 0, 0, 8'd0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 8'd0, 3'd0, 1'b0);
        checks++;
        if (dataOut !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset.data got %0d expected 0", dataOut);
        end
        rst = 1'b0;

        $display("[TB] applying %0d table vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus($sformatf("row%0d", i), vecs[i]);
        end

        // ---- Reset mid-group: leave a result queued and a partial group
        for (int j = 0; j < 4; j++) begin
            vec_t v;
            v.en = 1; v.clr = 0; v.sv = 1; v.rdy = 0; v.sample = 8'd200;
            v.expValid = (j == 3); v.expData = 8'd200;
            v.expLevel = (j == 3) ? 3'd1 : 3'd0; v.expOvf = 0;
            applyStimulus($sformatf("prerst%0d", j), v);
        end
        for (int j = 0; j < 2; j++) begin
            vec_t v;
            v.en = 1; v.clr = 0; v.sv = 1; v.rdy = 0; v.sample = 8'd100;
            v.expValid = 1; v.expData = 8'd200; v.expLevel = 3'd1; v.expOvf = 0;
            applyStimulus($sformatf("partial%0d", j), v);
        end
        idleInputs();
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset", 1'b0, 8'd0, 3'd0, 1'b0);
        checks++;
        if (dataOut !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset.data got %0d expected 0", dataOut);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            vec_t v;
            v.en = 1; v.clr = 0; v.sv = 1; v.rdy = 0; v.sample = 8'd8;
            v.expValid = (j == 3); v.expData = 8'd8;
            v.expLevel = (j == 3) ? 3'd1 : 3'd0; v.expOvf = 0;
            applyStimulus($sformatf("postrst%0d", j), v);
        end

        idleInputs();
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout reached at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
